register_read: RTL and testbench
================================

Name: register_read

Overview:
- Operand-fetch stage of the pipelined processor. It is the read-side counterpart of the register write-back unit.
- Owns the architectural register file. Accepts decoded instructions and reads two source registers.
- Tracks pending destination writes in a scoreboard and stalls on hazards.
- Absorbs write-back traffic (address + value) from the write-back stage.
- Emits a registered operand bundle to execute over a valid/ready handshake.

Parameters:
- NREGS, 16, number of 64-bit registers; R0 is hardwired zero.
- AW, 4, register address width (log2 NREGS).
- DW, 64, data width.
- CW, 8, opaque control bits passed through to execute.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_src_a  in  AW  source A address.
- in_src_b  in  AW  source B address.
- in_dest  in  AW  destination address.
- in_dest_we  in  1  instruction will write in_dest.
- in_ctrl  in  CW  control passthrough.
- wb_valid  in  1  write-back this cycle.
- wb_addr  in  AW  write-back address.
- wb_data  in  DW  write-back value.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_op_a  out  DW  value of src A.
- out_op_b  out  DW  value of src B.
- out_dest  out  AW  destination address.
- out_dest_we  out  1  destination write enable.
- out_ctrl  out  CW  control passthrough.

Behaviour:
- Reset (async, rst_n=0):
  - All registers = 0; pending[NREGS-1:0] = 0.
  - out_valid=0; out_op_a/out_op_b/out_dest/out_dest_we/out_ctrl = 0.
  - Reset mid-operation discards the held bundle and all pending state.
- Register file write:
  - On posedge, when wb_valid and wb_addr!=0: reg[wb_addr] <= wb_data.
  - wb_addr=0 is ignored.
  - Reads of R0 always return 0.
- Scoreboard:
  - pending[r] is set when an instruction with in_dest_we=1 and in_dest=r!=0 is accepted.
  - pending[r] is cleared when wb_valid and wb_addr=r.
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is always 0.
- Hazard, evaluated combinationally each cycle:
  - src_hazard(x) = pending[x] and not (bypass-resolved, see Optional Feature).
  - waw = in_dest_we and pending[in_dest] and not (wb_valid and wb_addr=in_dest).
  - stall = src_hazard(src_a) or src_hazard(src_b) or waw.
- Handshake:
  - slot_free = !out_valid or out_ready.
  - in_ready = slot_free and !stall. in_ready does not depend on in_valid.
  - Accept = in_valid and in_ready.
  - On accept: out_* <= operands/fields and out_valid <= 1. Latency is 1 cycle, accept to out_valid.
  - If out_ready and no accept, out_valid <= 0.
  - While out_valid and !out_ready, out_* holds stable.
- Operand value, when a source is not bypassed: the register-file content at the accept cycle.
- Throughput: one instruction per cycle when there are no hazards and out_ready=1.

Optional Feature:
- Macro: RR_BYPASS_EN.
- Defined:
  - A source x with wb_valid and wb_addr=x (x!=0) in the accept cycle takes wb_data.
  - That source is not a hazard even if pending[x]=1.
- Undefined:
  - No forwarding. A source pending in the cycle its write-back arrives still stalls.
  - The instruction is accepted the following cycle, reading the updated register.
  - Adds 1 stall cycle per dependent instruction.
- Both builds: WAW resolution by a same-cycle write-back is always allowed.

Test Plan:
- Reset then back-to-back: wb R3=0x11, R4=0x22; then issue src_a=3, src_b=4, out_ready=1.
  - Next cycle out_valid=1, op_a=0x11, op_b=0x22.
  - A second independent instruction is accepted the next cycle (no bubble).
- RAW stall: issue dest=5 (dest_we=1), then src_a=5.
  - in_ready=0 until wb R5=0xABCD.
  - With RR_BYPASS_EN: accepted that same cycle with op_a=0xABCD.
  - Without it: accepted one cycle later with op_a=0xABCD.
- Backpressure: out_ready=0 for 3 cycles with a bundle held.
  - out_* stable, in_ready=0.
  - Release: the held bundle is consumed and the next one is accepted the same cycle.
- R0 rules:
  - wb R0=0xFFFF leaves R0 unchanged.
  - An instruction with dest=0, dest_we=1 never sets pending.
  - A following src_a=0 is accepted immediately with op_a=0.
- WAW with simultaneous set/clear: R7 pending; new instruction dest=7 arrives in the same cycle as wb R7.
  - Accepted that cycle; pending[7] remains 1 afterwards.
- Async reset mid-stall: assert rst_n=0 while R9 is pending and out_valid=1.
  - out_valid=0 and pending=0 immediately.
  - After release, src_a=9 is accepted with op_a=0.

Source files
------------

// File: rtl/register_read.sv
// register_read: operand-fetch stage.
// Owns the architectural register file (R0 reads as zero), tracks pending
// destination writes in a scoreboard, stalls on RAW/WAW hazards, absorbs
// write-back traffic and presents a registered operand bundle to execute
// over a valid/ready handshake.
// Optional feature macro: RR_BYPASS_EN (forward same-cycle write-back data
// to sources; when undefined a pending source always stalls until the
// register file has been updated).
module register_read #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DW    = 64,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_src_a,
    input  logic [AW-1:0] in_src_b,
    input  logic [AW-1:0] in_dest,
    input  logic          in_dest_we,
    input  logic [CW-1:0] in_ctrl,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_op_a,
    output logic [DW-1:0] out_op_b,
    output logic [AW-1:0] out_dest,
    output logic          out_dest_we,
    output logic [CW-1:0] out_ctrl
);

    logic [DW-1:0]    rf_q [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    logic             out_valid_q;
    logic             out_valid_d;
    logic [DW-1:0]    out_op_a_q;
    logic [DW-1:0]    out_op_b_q;
    logic [AW-1:0]    out_dest_q;
    logic             out_dest_we_q;
    logic [CW-1:0]    out_ctrl_q;

    logic             haz_a;
    logic             haz_b;
    logic             waw;
    logic             stall;
    logic             slot_free;
    logic             accept;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;

    // Source hazard detection and operand selection for both read ports.
`ifdef RR_BYPASS_EN
    logic wb_hit_a;
    logic wb_hit_b;

    always_comb begin
        wb_hit_a = wb_valid && (wb_addr == in_src_a) && (in_src_a != '0);
        wb_hit_b = wb_valid && (wb_addr == in_src_b) && (in_src_b != '0);
        haz_a    = pending_q[in_src_a] && !wb_hit_a;
        haz_b    = pending_q[in_src_b] && !wb_hit_b;
        op_a     = (in_src_a == '0) ? '0 : (wb_hit_a ? wb_data : rf_q[in_src_a]);
        op_b     = (in_src_b == '0) ? '0 : (wb_hit_b ? wb_data : rf_q[in_src_b]);
    end
`else
    always_comb begin
        haz_a = pending_q[in_src_a];
        haz_b = pending_q[in_src_b];
        op_a  = (in_src_a == '0) ? '0 : rf_q[in_src_a];
        op_b  = (in_src_b == '0) ? '0 : rf_q[in_src_b];
    end
`endif

    // Stall decision and input/output handshake.
    always_comb begin
        waw         = in_dest_we && pending_q[in_dest]
                      && !(wb_valid && (wb_addr == in_dest));
        stall       = haz_a || haz_b || waw;
        slot_free   = !out_valid_q || out_ready;
        in_ready    = slot_free && !stall;
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard next state: clear on write-back, then set on accept so a
    // same-cycle set on the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_valid) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (accept && in_dest_we && (in_dest != '0)) begin
            pending_d[in_dest] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Register file write port; R0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_valid && (wb_addr != '0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Output bundle register; loads on accept, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_op_a_q    <= '0;
            out_op_b_q    <= '0;
            out_dest_q    <= '0;
            out_dest_we_q <= 1'b0;
            out_ctrl_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_op_a_q    <= op_a;
                out_op_b_q    <= op_b;
                out_dest_q    <= in_dest;
                out_dest_we_q <= in_dest_we;
                out_ctrl_q    <= in_ctrl;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op_a    = out_op_a_q;
    assign out_op_b    = out_op_b_q;
    assign out_dest    = out_dest_q;
    assign out_dest_we = out_dest_we_q;
    assign out_ctrl    = out_ctrl_q;

endmodule

// File: tb/tb_register_read.sv
// Testbench for register_read: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of the stage.
module tb_register_read;

    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int CW    = 8;
`ifdef RR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_src_a;
    logic [AW-1:0] in_src_b;
    logic [AW-1:0] in_dest;
    logic          in_dest_we;
    logic [CW-1:0] in_ctrl;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_op_a;
    logic [DW-1:0] out_op_b;
    logic [AW-1:0] out_dest;
    logic          out_dest_we;
    logic [CW-1:0] out_ctrl;

    register_read #(.NREGS(NREGS), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src_a(in_src_a), .in_src_b(in_src_b),
        .in_dest(in_dest), .in_dest_we(in_dest_we), .in_ctrl(in_ctrl),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_dest(out_dest), .out_dest_we(out_dest_we), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] dest;
        logic          we;
        logic [CW-1:0] ctrl;
    } bundle_t;

    bundle_t       q[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference model state: architectural registers, pending flags, output slot.
    logic [DW-1:0] mregs [NREGS];
    bit            mpend [NREGS];
    bit            m_valid;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
        m_valid = 1'b0;
        q.delete();
    endtask

    // Monitor: whenever the DUT presents a bundle it must match the oldest
    // expected one; it is retired when execute takes it.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
            if (out_valid && q.size() > 0) begin
                chk("out_op_a", out_op_a, q[0].a);
                chk("out_op_b", out_op_b, q[0].b);
                chk("out_dest", {60'd0, out_dest}, {60'd0, q[0].dest});
                chk("out_dest_we", {63'd0, out_dest_we}, {63'd0, q[0].we});
                chk("out_ctrl", {56'd0, out_ctrl}, {56'd0, q[0].ctrl});
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // One clock of stimulus: drive, predict in_ready and the bundle from the
    // model, then advance the model across the clock edge.
    task automatic cycle(input bit iv, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic [AW-1:0] d, input bit dwe, input logic [CW-1:0] c,
                         input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input bit ordy, output bit acc);
        bit      fwd_a, fwd_b, stall, er;
        bundle_t bnd;
        in_valid = iv; in_src_a = sa; in_src_b = sb; in_dest = d; in_dest_we = dwe;
        in_ctrl = c; wb_valid = wv; wb_addr = wa; wb_data = wd; out_ready = ordy;
        @(negedge clk);
        fwd_a = BYP && wv && (wa == sa) && (sa != 0);
        fwd_b = BYP && wv && (wa == sb) && (sb != 0);
        stall = (mpend[sa] && !fwd_a) || (mpend[sb] && !fwd_b)
                || (dwe && mpend[d] && !(wv && wa == d));
        er    = (!m_valid || ordy) && !stall;
        chk("in_ready", {63'd0, in_ready}, {63'd0, er});
        acc      = iv && er;
        bnd.a    = (sa == 0) ? '0 : (fwd_a ? wd : mregs[sa]);
        bnd.b    = (sb == 0) ? '0 : (fwd_b ? wd : mregs[sb]);
        bnd.dest = d;
        bnd.we   = dwe;
        bnd.ctrl = c;
        @(posedge clk);
        #1;
        if (acc) m_valid = 1'b1;
        else if (ordy) m_valid = 1'b0;
        if (wv && wa != 0) mregs[wa] = wd;
        if (wv) mpend[wa] = 1'b0;
        if (acc && dwe && d != 0) mpend[d] = 1'b1;
        if (acc) q.push_back(bnd);
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, '0, ordy, acc);
    endtask

    initial begin
        bit            acc;
        int            npend;
        logic [AW-1:0] plist [NREGS];
        logic [AW-1:0] wa;

        rst_n = 1'b0;
        in_valid = 0; in_src_a = 0; in_src_b = 0; in_dest = 0; in_dest_we = 0;
        in_ctrl = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
        model_reset();
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, '0);
        chk("rst_out_op_a", out_op_a, '0);
        chk("rst_out_op_b", out_op_b, '0);
        chk("rst_out_dest", {60'd0, out_dest}, '0);
        chk("rst_out_dest_we", {63'd0, out_dest_we}, '0);
        chk("rst_out_ctrl", {56'd0, out_ctrl}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill R3/R4, then two back-to-back independent reads.
        cycle(0, 0, 0, 0, 0, 0, 1, 3, 64'h11, 1, acc);
        cycle(0, 0, 0, 0, 0, 0, 1, 4, 64'h22, 1, acc);
        cycle(1, 3, 4, 1, 0, 8'hA1, 0, 0, '0, 1, acc);
        chk("b2b_first_acc", {63'd0, acc}, 64'd1);
        cycle(1, 4, 3, 2, 0, 8'hA2, 0, 0, '0, 1, acc);
        chk("b2b_second_acc", {63'd0, acc}, 64'd1);
        idle(1);

        // RAW on R5.
        cycle(1, 0, 0, 5, 1, 8'hB0, 0, 0, '0, 1, acc);
        cycle(1, 5, 0, 6, 0, 8'hB1, 0, 0, '0, 1, acc);
        chk("raw_stalled", {63'd0, acc}, '0);
        cycle(1, 5, 0, 6, 0, 8'hB1, 1, 5, 64'hABCD, 1, acc);
        chk("raw_wb_cycle_acc", {63'd0, acc}, {63'd0, BYP});
        if (!acc) begin
            cycle(1, 5, 0, 6, 0, 8'hB1, 0, 0, '0, 1, acc);
            chk("raw_next_cycle_acc", {63'd0, acc}, 64'd1);
        end
        idle(1);

        // Backpressure: hold a bundle for three cycles, then release.
        cycle(1, 3, 4, 8, 0, 8'hC0, 0, 0, '0, 0, acc);
        repeat (3) cycle(1, 4, 4, 8, 0, 8'hC1, 0, 0, '0, 0, acc);
        cycle(1, 4, 4, 8, 0, 8'hC1, 0, 0, '0, 1, acc);
        chk("bp_release_acc", {63'd0, acc}, 64'd1);
        idle(1);

        // R0 rules.
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 64'hFFFF, 1, acc);
        cycle(1, 0, 0, 0, 1, 8'hD0, 0, 0, '0, 1, acc);
        cycle(1, 0, 0, 1, 0, 8'hD1, 0, 0, '0, 1, acc);
        chk("r0_src_acc", {63'd0, acc}, 64'd1);
        idle(1);

        // WAW with simultaneous set/clear on R7.
        cycle(1, 0, 0, 7, 1, 8'hE0, 0, 0, '0, 1, acc);
        cycle(1, 0, 0, 7, 1, 8'hE1, 1, 7, 64'h77, 1, acc);
        chk("waw_acc", {63'd0, acc}, 64'd1);
        cycle(1, 7, 0, 1, 0, 8'hE2, 0, 0, '0, 1, acc);
        chk("waw_still_pending", {63'd0, acc}, '0);
        cycle(0, 0, 0, 0, 0, 0, 1, 7, 64'h78, 1, acc);

        // Async reset while R9 pending and a bundle is held.
        cycle(1, 0, 0, 9, 1, 8'hF0, 0, 0, '0, 0, acc);
        in_valid = 1'b0; in_src_a = 9; in_src_b = 0; in_dest = 1; in_dest_we = 0;
        wb_valid = 0; out_ready = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, '0);
        chk("arst_pending_clear", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(1, 9, 0, 1, 0, 8'hF1, 0, 0, '0, 1, acc);
        chk("arst_src9_acc", {63'd0, acc}, 64'd1);

        // Randomized traffic; write-backs lean towards pending registers.
        for (int i = 0; i < 1500; i++) begin
            npend = 0;
            for (int r = 1; r < NREGS; r++) if (mpend[r]) plist[npend++] = AW'(r);
            wa = AW'($urandom_range(0, NREGS - 1));
            if (npend > 0 && $urandom_range(0, 3) != 0) wa = plist[$urandom_range(0, npend - 1)];
            cycle($urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                  CW'($urandom), $urandom_range(0, 1) == 1, wa,
                  {$urandom, $urandom}, $urandom_range(0, 3) != 0, acc);
        end
        repeat (3) idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
